// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from NREQ requesters to one UART sender.
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   req_valid[NREQ]    per-requester byte-pending level
//   req_data[8*NREQ]   byte for requester i on bits [8i+7:8i]
//   req_ack[NREQ]      one-cycle pulse when requester i's byte is latched
//   tx_req             one-cycle send request to the sender
//   tx_data[8]         byte to the sender, held until the next grant
//   tx_done            sender completion, only a rising edge counts
//   busy               high from grant until the gap phase ends
//   active_id[3]       current or last granted requester
//   timeout_err        sticky, set on any forced release
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 5000,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic [2:0]        active_id,
  output logic              timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
  state_t      state;
  logic [2:0]  last_grant;
  logic [15:0] cnt;
  logic [15:0] gcnt;
  logic        done_q;
  logic [2:0]  win;
  logic [7:0]  win_data;
  logic        any;
  // Later matches overwrite earlier ones, so scanning k downwards leaves the
  // requester closest after last_grant as the winner.
  always_comb begin
    win      = '0;
    win_data = '0;
    any      = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      for (int j = 0; j < NREQ; j++)
        if (req_valid[j] && j == (int'(last_grant) + k) % NREQ) begin
          win      = 3'(j);
          win_data = req_data[8*j +: 8];
          any      = 1'b1;
        end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ack     <= '0;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      active_id   <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      gcnt        <= '0;
      done_q      <= 1'b0;
      last_grant  <= 3'(NREQ-1);
    end else begin
      req_ack <= '0;
      tx_req  <= 1'b0;
      case (state)
        S_IDLE:
          if (any) begin
            tx_data    <= win_data;
            active_id  <= win;
            last_grant <= win;
            req_ack    <= NREQ'(1) << win;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        S_ISSUE: begin
          tx_req <= 1'b1;
          cnt    <= '0;
          done_q <= tx_done;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          done_q <= tx_done;
          // A completion edge takes priority over a timeout in the same cycle.
          if (tx_done && !done_q) begin
            gcnt  <= '0;
            state <= S_GAP;
          end else if (cnt == 16'(TIMEOUT-1)) begin
            timeout_err <= 1'b1;
            gcnt        <= '0;
            state       <= S_GAP;
          end else
            cnt <= cnt + 16'd1;
        end
        S_GAP:
          // GAP of 0 or 1 still spends exactly one cycle here.
          if (32'(gcnt) + 1 >= GAP) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else
            gcnt <= gcnt + 16'd1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, corner sequences and random traffic against a round-robin model.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [2:0]  active_id;
  logic        timeout_err;
  int total = 0;
  int bad = 0;
  int mlast = 3;
  localparam logic [31:0] D = 32'hD3D2D1D0;

  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(5000), .GAP(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .active_id(active_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    int          dly;
    int          id;
    logic [7:0]  b;
  } vec_t;
  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txreq"}, 32'(tx_req), 0);
    chk({tag, "_txdata"}, 32'(tx_data), 0);
    chk({tag, "_ack"}, 32'(req_ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_id"}, 32'(active_id), 0);
    chk({tag, "_tmo"}, 32'(timeout_err), 0);
  endtask

  function automatic int rr(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tx_done = 1'b0;
    step();
    reset = 1'b0;
    mlast = 3;
  endtask

  // Presents a request, checks the ack cycle and the tx_req cycle; returns in the first WAIT cycle.
  task automatic grant(input logic [3:0] v, input logic [31:0] d, input int id, input logic [7:0] b);
    req_valid = v;
    req_data = d;
    step();
    chk("ack", 32'(req_ack), 32'(1) << id);
    chk("active_id", 32'(active_id), 32'(id));
    chk("busy_grant", 32'(busy), 1);
    chk("txreq_early", 32'(tx_req), 0);
    req_valid = '0;
    step();
    chk("txreq", 32'(tx_req), 1);
    chk("txdata", 32'(tx_data), 32'(b));
    chk("ack_once", 32'(req_ack), 0);
    mlast = id;
  endtask

  task automatic finish_xfer(input int dly, input logic [7:0] b, input logic scramble);
    for (int i = 0; i < dly; i++) begin
      if (scramble) begin
        req_valid = 4'($urandom);
        req_data = $urandom;
      end
      step();
      chk("txreq_single", 32'(tx_req), 0);
      chk("hold_data", 32'(tx_data), 32'(b));
      chk("busy_wait", 32'(busy), 1);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("busy_gap1", 32'(busy), 1);
    step();
    chk("busy_gap2", 32'(busy), 1);
    req_valid = '0;
    step();
    chk("busy_idle", 32'(busy), 0);
    chk("keep_data", 32'(tx_data), 32'(b));
  endtask

  initial begin
    int np;
    int ids[5];
    logic [7:0] bytes[5];
    int cyc[5];
    tbl[0] = '{4'b0001, 32'h00000055, 0, 0, 8'h55};
    tbl[1] = '{4'b1111, D, 1, 1, 8'hD1};
    tbl[2] = '{4'b1111, D, 3, 2, 8'hD2};
    tbl[3] = '{4'b1111, D, 0, 3, 8'hD3};
    tbl[4] = '{4'b1111, D, 2, 0, 8'hD0};
    tbl[5] = '{4'b0100, D, 1, 2, 8'hD2};
    tbl[6] = '{4'b1001, D, 0, 3, 8'hD3};
    tbl[7] = '{4'b0011, D, 4, 0, 8'hD0};

    step();
    step();
    chk_reset_vals("reset");
    reset = 1'b0;
    step();
    chk_reset_vals("after_reset");

    for (int i = 0; i < 8; i++) begin
      grant(tbl[i].v, tbl[i].d, tbl[i].id, tbl[i].b);
      finish_xfer(tbl[i].dly, tbl[i].b, 1'b0);
    end

    // Completion edge on the very cycle the timeout would fire.
    grant(4'b0100, D, 2, 8'hD2);
    repeat (4999) step();
    chk("simul_pre_tmo", 32'(timeout_err), 0);
    tx_done = 1'b1;
    step();
    chk("simul_tmo", 32'(timeout_err), 0);
    chk("simul_busy", 32'(busy), 1);
    tx_done = 1'b0;
    step();
    step();
    chk("simul_idle", 32'(busy), 0);

    // tx_done stuck high from before tx_req: only the timeout releases.
    tx_done = 1'b1;
    grant(4'b1000, D, 3, 8'hD3);
    repeat (4999) step();
    chk("stuck_pre_tmo", 32'(timeout_err), 0);
    chk("stuck_busy", 32'(busy), 1);
    step();
    chk("stuck_tmo", 32'(timeout_err), 1);
    tx_done = 1'b0;
    step();
    step();
    grant(4'b0010, D, 1, 8'hD1);
    finish_xfer(1, 8'hD1, 1'b0);
    chk("tmo_sticky", 32'(timeout_err), 1);

    // Asynchronous reset in WAIT aborts the transfer.
    grant(4'b0110, D, 2, 8'hD2);
    req_valid = 4'b0110;
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_wait");
    step();
    step();
    chk("rst_no_ack", 32'(req_ack), 0);
    chk("rst_no_txreq", 32'(tx_req), 0);
    reset = 1'b0;
    mlast = 3;
    grant(4'b0110, D, 1, 8'hD1);
    finish_xfer(0, 8'hD1, 1'b0);

    // All requesters held: order, data and tx_req spacing with done answered immediately.
    do_reset();
    req_valid = 4'hF;
    req_data = D;
    np = 0;
    for (int c = 0; c < 60 && np < 5; c++) begin
      step();
      tx_done = tx_req;
      if (tx_req) begin
        ids[np] = int'(active_id);
        bytes[np] = tx_data;
        cyc[np] = c;
        np++;
      end
    end
    req_valid = '0;
    step();
    tx_done = 1'b0;
    repeat (3) step();
    chk("spc_count", 32'(np), 5);
    for (int i = 0; i < np; i++) begin
      chk("spc_id", 32'(ids[i]), 32'(i % 4));
      chk("spc_data", 32'(bytes[i]), (D >> (8 * (i % 4))) & 32'hFF);
    end
    for (int i = 1; i < np; i++) chk("spc_gap", 32'(cyc[i] - cyc[i-1]), 5);
    mlast = 0;

    // Random traffic against the round-robin model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] v;
      logic [31:0] d;
      int id;
      v = 4'($urandom_range(1, 15));
      d = $urandom;
      id = rr(v, mlast);
      grant(v, d, id, 8'(d >> (8 * id)));
      finish_xfer(int'($urandom_range(0, 6)), 8'(d >> (8 * id)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 5000, is the max cycles from tx_req to completion before forced release (exceeds 10 bits x 435 cycles).
REQ-003 Parameter GAP, default 2, is the idle cycles enforced between successive tx_req pulses.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  NREQ  per-requester byte-pending level.
REQ-007 req_data  in  8*NREQ  byte for requester i on bits [8i+7:8i].
REQ-008 req_ack  out  NREQ  one-cycle pulse: requester i's byte was latched and it may drop or change req_valid/req_data.
REQ-009 tx_req  out  1  one-cycle send request to the UART sender.
REQ-010 tx_data  out  8  byte to the sender, stable from tx_req until release.
REQ-011 tx_done  in  1  sender completion; only a 0->1 transition counts.
REQ-012 busy  out  1  high from grant until the GAP phase ends.
REQ-013 active_id  out  3  index of the current or last granted requester.
REQ-014 timeout_err  out  1  sticky flag, set on any forced release.

Function
REQ-015 States: IDLE, ISSUE, WAIT, GAP.
REQ-016 IDLE: if any req_valid is high, grant round-robin starting at (last_grant+1) mod NREQ and go to ISSUE; otherwise stay in IDLE.
REQ-017 On grant: latch req_data of the winner into tx_data, load active_id, and pulse req_ack[winner] for exactly one cycle in the same cycle.
REQ-018 ISSUE: assert tx_req for one cycle, clear the timeout counter, and capture tx_done into a prior-sample register; go to WAIT.
REQ-019 WAIT: a tx_done rising edge (current=1, prior=0) moves to GAP; a tx_done that stays high from ISSUE onward is not completion.
REQ-020 WAIT: a 16-bit counter increments each cycle; when it reaches TIMEOUT-1 with no edge, set timeout_err and move to GAP.
REQ-021 If an edge and the timeout fall in the same cycle, the edge wins and timeout_err is not set.
REQ-022 GAP: hold for exactly GAP cycles, then return to IDLE; GAP=0 returns to IDLE on the next cycle.
REQ-023 last_grant updates only on grant and wraps NREQ-1 -> 0.
REQ-024 req_valid changes during ISSUE/WAIT/GAP do not affect the transfer in flight; arbitration is sampled only in IDLE.
REQ-025 A requester holding req_valid continuously wins at most once per NREQ grants while others are also pending.
REQ-026 Minimum spacing of tx_req pulses is 3+GAP cycles.
REQ-027 tx_data holds its value outside transfers; it is not cleared after completion.

Reset
REQ-028 While reset is high: state=IDLE, tx_req=0, tx_data=0, req_ack=0, busy=0, active_id=0, timeout_err=0, counters=0, prior-sample=0, last_grant=NREQ-1 (so requester 0 has first priority).
REQ-029 Reset asserted mid-transfer aborts it immediately with no req_ack or tx_req afterwards; the first grant after release starts again at requester 0.

Verification
REQ-030 Single request: req_valid=0001, data0=0x55 -> req_ack=0001 one cycle, tx_req one cycle later with tx_data=0x55, busy until done edge+GAP.
REQ-031 All pending: req_valid=1111 held with distinct bytes, done pulsed each time -> grant order 0,1,2,3,0 and matching tx_data sequence.
REQ-032 Stuck done: tx_done held at 1 from before tx_req -> no completion, timeout after 5000 cycles, timeout_err=1, and the next grant proceeds.
REQ-033 Simultaneous: done edge exactly on cycle TIMEOUT-1 -> GAP entered, timeout_err stays 0.
REQ-034 Reset in WAIT: assert reset mid-transfer with req_valid=0110 -> all outputs at reset values; after release, grant goes to requester 1.
REQ-035 Spacing: back-to-back requests with done pulsed on the cycle after tx_req -> tx_req pulses exactly 3+GAP=5 cycles apart.
